// File: rtl/ram_pkg.sv
// Shared RAM types and helpers.
// Used by the dual-port RAM and its read pipeline.
package ram_pkg;

  typedef enum logic {
    WRITE_FIRST = 1'b0,
    READ_FIRST  = 1'b1
  } rw_mode_e;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } ram_state_e;

  function automatic int be_width(int dw);
    return dw / 8;
  endfunction

  function automatic bit params_ok(
    int dw,
    int aw,
    int depth,
    int lat,
    int rwm,
    int apri
  );
    return (dw > 0) && (dw % 8 == 0)
        && (aw > 0) && (aw < 31)
        && (depth >= 1)
        && (depth <= (1 << aw))
        && (lat == 1 || lat == 2)
        && (rwm == 0 || rwm == 1)
        && (apri == 0 || apri == 1);
  endfunction

endpackage

// File: rtl/dual_port_ram_if.sv
// One RAM access port: request, write data,
// byte enables and registered read response.
interface dual_port_ram_if
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  localparam int BE_WIDTH = be_width(DATA_WIDTH);

  logic                  en;
  logic                  ready;
  logic                  wr;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_WIDTH-1:0]   be;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  err;

  modport master (
    output en, wr, addr, wdata, be,
    input  ready, rdata, rvalid, err
  );

  modport slave (
    input  en, wr, addr, wdata, be,
    output ready, rdata, rvalid, err
  );

endinterface

// File: rtl/ram_rd_pipe.sv
// Read response delay line, 1 or 2 stages.
// rdata holds between valid pulses.
module ram_rd_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  in_err,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic                  out_err,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic                  v1;
  logic                  e1;
  logic [DATA_WIDTH-1:0] d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      e1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= in_valid;
      e1 <= in_err;
      if (in_valid) d1 <= in_data;
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic                  v2;
    logic                  e2;
    logic [DATA_WIDTH-1:0] d2;

    always_ff @(posedge clk) begin
      if (rst) begin
        v2 <= 1'b0;
        e2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        e2 <= e1;
        if (v1) d2 <= d1;
      end
    end

    assign out_valid = v2;
    assign out_err   = e2;
    assign out_data  = d2;
  end else begin : g_lat1
    assign out_valid = v1;
    assign out_err   = e1;
    assign out_data  = d1;
  end

endmodule

// File: rtl/dual_port_ram.sv
// True dual-port RAM with zero-init after reset,
// byte enables, collision arbitration, range check.
module dual_port_ram
  import ram_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int RD_LATENCY = 1,
  parameter int RW_MODE    = 0,
  parameter int A_PRIORITY = 1
) (
  input  logic           clk,
  input  logic           rst,
  dual_port_ram_if.slave a,
  dual_port_ram_if.slave b,
  output logic           busy,
  output logic           collision
);

  if (!params_ok(DATA_WIDTH, ADDR_WIDTH, DEPTH,
                 RD_LATENCY, RW_MODE, A_PRIORITY))
  begin : g_bad_params
    $fatal(1, "dual_port_ram: illegal parameters");
  end

  localparam int BW = be_width(DATA_WIDTH);

  localparam logic [ADDR_WIDTH:0] DEPTH_W =
    (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam rw_mode_e MODE =
    (RW_MODE == 1) ? READ_FIRST : WRITE_FIRST;

  typedef logic [BW-1:0][7:0] word_t;

  ram_state_e            state;
  ram_state_e            state_nx;
  logic [ADDR_WIDTH-1:0] init_cnt;
  logic [ADDR_WIDTH-1:0] init_cnt_nx;

  word_t mem [DEPTH];

  logic    a_acc, b_acc;
  logic    a_in, b_in;
  logic    a_we, b_we;
  logic    same;
  logic [BW-1:0] a_wm, b_wm;
  word_t   a_wd, b_wd;
  word_t   a_old, b_old;
  word_t   a_rd, b_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nx;
      init_cnt <= init_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    init_cnt_nx = init_cnt;
    unique case (state)
      INIT: begin
        init_cnt_nx = init_cnt + 1'b1;
        if (init_cnt == LAST) begin
          state_nx    = RUN;
          init_cnt_nx = '0;
        end
      end
      RUN: state_nx = RUN;
    endcase
  end

  assign busy    = (state == INIT);
  assign a.ready = (state == RUN);
  assign b.ready = (state == RUN);

  // a request seen on the reset edge is never taken
  assign a_acc = a.en && a.ready && !rst;
  assign b_acc = b.en && b.ready && !rst;
  assign a_in  = {1'b0, a.addr} < DEPTH_W;
  assign b_in  = {1'b0, b.addr} < DEPTH_W;
  assign a_we  = a_acc && a.wr && a_in;
  assign b_we  = b_acc && b.wr && b_in;
  assign same  = (a.addr == b.addr);
  assign a_wd  = a.wdata;
  assign b_wd  = b.wdata;

  // losing port keeps only the bytes the winner leaves alone
  always_comb begin
    a_wm = a_we ? a.be : '0;
    b_wm = b_we ? b.be : '0;
    if (a_we && b_we && same) begin
      if (A_PRIORITY != 0) b_wm = b.be & ~a.be;
      else                 a_wm = a.be & ~b.be;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == INIT) mem[init_cnt] <= '0;
    for (int i = 0; i < BW; i++) begin
      if (a_wm[i]) mem[a.addr][i] <= a_wd[i];
      if (b_wm[i]) mem[b.addr][i] <= b_wd[i];
    end
  end

  always_comb begin
    a_old = a_in ? mem[a.addr] : '0;
    b_old = b_in ? mem[b.addr] : '0;
    a_rd  = a_old;
    b_rd  = b_old;
    if (MODE == WRITE_FIRST && same) begin
      for (int i = 0; i < BW; i++) begin
        if (b_wm[i]) a_rd[i] = b_wd[i];
        if (a_wm[i]) b_rd[i] = a_wd[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) collision <= 1'b0;
    else     collision <= a_we && b_we && same;
  end

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_acc && !a.wr),
    .in_err    (a_acc && !a_in),
    .in_data   (a_rd),
    .out_valid (a.rvalid),
    .out_err   (a.err),
    .out_data  (a.rdata)
  );

  ram_rd_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_pipe_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_acc && !b.wr),
    .in_err    (b_acc && !b_in),
    .in_data   (b_rd),
    .out_valid (b.rvalid),
    .out_err   (b.err),
    .out_data  (b.rdata)
  );

endmodule

// File: tb/tb_dual_port_ram.sv
// Two RAM configs driven by one stimulus stream,
// compared cycle by cycle with a behavioural model.
module tb_dual_port_ram;

  localparam int DW   = 32;
  localparam int AW   = 4;
  localparam int NC   = 2;
  localparam int RING = 8;

  function automatic int dep(int k);
    return (k == 0) ? 16 : 12;
  endfunction
  function automatic int lat(int k);
    return (k == 0) ? 1 : 2;
  endfunction
  function automatic int rwm(int k);
    return (k == 0) ? 0 : 1;
  endfunction
  function automatic int apri(int k);
    return (k == 0) ? 1 : 0;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   armed = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  logic          en    [2];
  logic          wr    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [3:0]    be    [2];

  dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a0 ();
  dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
  dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
  dual_port_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

  logic busy0, busy1, col0, col1;

  assign a0.en = en[0];    assign a1.en = en[0];
  assign a0.wr = wr[0];    assign a1.wr = wr[0];
  assign a0.addr = addr[0];   assign a1.addr = addr[0];
  assign a0.wdata = wdata[0]; assign a1.wdata = wdata[0];
  assign a0.be = be[0];    assign a1.be = be[0];
  assign b0.en = en[1];    assign b1.en = en[1];
  assign b0.wr = wr[1];    assign b1.wr = wr[1];
  assign b0.addr = addr[1];   assign b1.addr = addr[1];
  assign b0.wdata = wdata[1]; assign b1.wdata = wdata[1];
  assign b0.be = be[1];    assign b1.be = be[1];

  dual_port_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(16),
    .RD_LATENCY(1), .RW_MODE(0), .A_PRIORITY(1)
  ) dut0 (
    .clk(clk), .rst(rst), .a(a0), .b(b0),
    .busy(busy0), .collision(col0)
  );

  dual_port_ram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(12),
    .RD_LATENCY(2), .RW_MODE(1), .A_PRIORITY(0)
  ) dut1 (
    .clk(clk), .rst(rst), .a(a1), .b(b1),
    .busy(busy1), .collision(col1)
  );

  logic          o_rv  [NC][2];
  logic          o_er  [NC][2];
  logic          o_rdy [NC][2];
  logic [DW-1:0] o_rd  [NC][2];
  logic          o_busy [NC];
  logic          o_col  [NC];

  assign o_rv[0][0] = a0.rvalid;  assign o_rv[0][1] = b0.rvalid;
  assign o_rv[1][0] = a1.rvalid;  assign o_rv[1][1] = b1.rvalid;
  assign o_er[0][0] = a0.err;     assign o_er[0][1] = b0.err;
  assign o_er[1][0] = a1.err;     assign o_er[1][1] = b1.err;
  assign o_rdy[0][0] = a0.ready;  assign o_rdy[0][1] = b0.ready;
  assign o_rdy[1][0] = a1.ready;  assign o_rdy[1][1] = b1.ready;
  assign o_rd[0][0] = a0.rdata;   assign o_rd[0][1] = b0.rdata;
  assign o_rd[1][0] = a1.rdata;   assign o_rd[1][1] = b1.rdata;
  assign o_busy[0] = busy0;       assign o_busy[1] = busy1;
  assign o_col[0] = col0;         assign o_col[1] = col1;

  // model: word array, busy countdown, responses keyed by due cycle
  logic [DW-1:0] mmem [NC][16];
  int            init_left [NC];
  bit            ev [NC][2][RING];
  bit            ee [NC][2][RING];
  logic [DW-1:0] ed [NC][2][RING];
  bit            ec [NC][RING];
  logic [DW-1:0] last_rd [NC][2];

  task automatic check(string tag, logic [DW-1:0] got,
                       logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset(int k);
    init_left[k] = dep(k);
    for (int s = 0; s < RING; s++) begin
      ec[k][s] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        ev[k][p][s] = 1'b0;
        ee[k][p][s] = 1'b0;
      end
    end
    last_rd[k][0] = '0;
    last_rd[k][1] = '0;
    for (int i = 0; i < 16; i++) mmem[k][i] = '0;
  endtask

  task automatic model_edge(int k);
    bit            inr [2];
    logic [DW-1:0] rdv;
    int            s, q, p;
    if (rst) begin
      model_reset(k);
      return;
    end
    if (init_left[k] > 0) begin
      init_left[k]--;
      return;
    end
    for (int i = 0; i < 2; i++) inr[i] = int'(addr[i]) < dep(k);
    s = (cyc + lat(k)) % RING;
    for (int i = 0; i < 2; i++) begin
      if (en[i]) begin
        ee[k][i][s] = !inr[i];
        if (!wr[i]) begin
          q = 1 - i;
          rdv = inr[i] ? mmem[k][addr[i]] : '0;
          if (rwm(k) == 0 && inr[i] && en[q] && wr[q]
              && addr[q] == addr[i])
            for (int j = 0; j < 4; j++)
              if (be[q][j]) rdv[8*j +: 8] = wdata[q][8*j +: 8];
          ev[k][i][s] = 1'b1;
          ed[k][i][s] = rdv;
        end
      end
    end
    if (en[0] && wr[0] && en[1] && wr[1] && inr[0] && inr[1]
        && addr[0] == addr[1])
      ec[k][(cyc + 1) % RING] = 1'b1;
    // lower-priority port written first, winner overwrites
    for (int n = 0; n < 2; n++) begin
      p = (n == 0) ? apri(k) : 1 - apri(k);
      if (en[p] && wr[p] && inr[p])
        for (int j = 0; j < 4; j++)
          if (be[p][j])
            mmem[k][addr[p]][8*j +: 8] = wdata[p][8*j +: 8];
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < NC; k++) begin
        int s;
        s = cyc % RING;
        for (int p = 0; p < 2; p++) begin
          string pn;
          pn = $sformatf("d%0d.%s@%0d", k, p ? "b" : "a", cyc);
          if (ev[k][p][s]) last_rd[k][p] = ed[k][p][s];
          check({pn, ".rvalid"}, DW'(o_rv[k][p]), DW'(ev[k][p][s]));
          check({pn, ".rdata"}, o_rd[k][p], last_rd[k][p]);
          check({pn, ".err"}, DW'(o_er[k][p]), DW'(ee[k][p][s]));
          check({pn, ".ready"}, DW'(o_rdy[k][p]),
                DW'(init_left[k] == 0));
          ev[k][p][s] = 1'b0;
          ee[k][p][s] = 1'b0;
        end
        check($sformatf("d%0d.busy@%0d", k, cyc),
              DW'(o_busy[k]), DW'(init_left[k] > 0));
        check($sformatf("d%0d.collision@%0d", k, cyc),
              DW'(o_col[k]), DW'(ec[k][s]));
        ec[k][s] = 1'b0;
        model_edge(k);
      end
      cyc++;
    end
  end

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      en[p] = 1'b0;
      wr[p] = 1'b0;
      addr[p] = '0;
      wdata[p] = '0;
      be[p] = '0;
    end
  endtask

  task automatic op(int p, logic w, logic [AW-1:0] ad,
                    logic [DW-1:0] d, logic [3:0] b);
    en[p] = 1'b1;
    wr[p] = w;
    addr[p] = ad;
    wdata[p] = d;
    be[p] = b;
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [AW-1:0] pick_addr();
    if ($urandom_range(0, 3) == 0)
      return AW'($urandom_range(0, 15));
    return AW'($urandom_range(2, 5));
  endfunction

  initial begin
    idle();
    rst = 1'b1;
    model_reset(0);
    model_reset(1);
    @(posedge clk);
    #1;
    armed = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(18);
    // every word reads back zero after init
    for (int i = 0; i < 16; i++) begin
      idle();
      op(0, 1'b0, AW'(i), '0, 4'h0);
      op(1, 1'b0, AW'(15 - i), '0, 4'h0);
      tick(1);
    end
    idle(); tick(3);
    // byte enables
    op(0, 1'b1, 4'd3, 32'hAABBCCDD, 4'hF); tick(1);
    idle(); op(0, 1'b1, 4'd3, 32'h11223344, 4'h5); tick(1);
    idle(); op(1, 1'b0, 4'd3, '0, 4'h0); tick(1);
    idle(); tick(3);
    // back-to-back reads
    for (int i = 0; i < 3; i++) begin
      idle(); op(0, 1'b0, AW'(i), '0, 4'h0); tick(1);
    end
    idle(); tick(3);
    // read during write
    op(0, 1'b1, 4'd7, 32'h9, 4'hF); tick(1);
    idle();
    op(0, 1'b1, 4'd7, 32'h5, 4'hF);
    op(1, 1'b0, 4'd7, '0, 4'h0);
    tick(1);
    idle(); tick(3);
    // write-write collision
    op(0, 1'b1, 4'd4, 32'h1, 4'hF);
    op(1, 1'b1, 4'd4, 32'h2, 4'hF);
    tick(1);
    idle(); tick(1);
    op(0, 1'b0, 4'd4, '0, 4'h0); tick(1);
    idle(); tick(3);
    // out of range on the 12-word instance
    op(0, 1'b1, 4'd13, 32'hDEADBEEF, 4'hF); tick(1);
    idle(); op(0, 1'b0, 4'd13, '0, 4'h0); tick(1);
    idle(); tick(3);
    // reset while a read is in flight
    op(0, 1'b0, 4'd5, '0, 4'h0); tick(1);
    idle(); rst = 1'b1; tick(1);
    rst = 1'b0; tick(20);
    for (int n = 0; n < 3000; n++) begin
      idle();
      rst = ($urandom_range(0, 599) == 0);
      for (int p = 0; p < 2; p++)
        if ($urandom_range(0, 3) != 0)
          op(p, 1'($urandom_range(0, 1)), pick_addr(),
             DW'($urandom), 4'($urandom));
      tick(1);
    end
    idle();
    rst = 1'b0;
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
